multi_cycle_controller: RTL and testbench

Multi-cycle MIPS control unit that replaces the single-cycle combinational decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It stalls on a ready handshake from memory and I/O, decodes memory-mapped I/O into a parametrised one-hot device bus, and aborts stalled accesses on timeout. It sits between the IR/PC datapath, the ALU, data memory and the I/O bridge in the CPU top.

---
 rtl/cpu_defs.sv | 49 ++++
 rtl/io_device_decoder.sv | 28 ++
 rtl/multi_cycle_controller.sv | 210 +++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, functs,
// state encoding, PC-source / ALU-op encodings and small decode helpers.
package cpu_defs;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] ALU_OP_MEM    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // I/O space is the region whose upper address bits are all this value
  localparam logic IO_ADDR_HIGH_FILL = 1'b1;

  function automatic logic is_arith_i(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

  function automatic logic is_shift_funct(input logic [5:0] fn);
    return (fn == 6'b000000) || (fn == 6'b000010) || (fn == 6'b000011) ||
           (fn == 6'b000100) || (fn == 6'b000110) || (fn == 6'b000111);
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || is_arith_i(op) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/io_device_decoder.sv
// Combinational one-hot I/O select decoder with range check; shared with the
// bus bridge so both sides agree on which device an index addresses.
module io_device_decoder #(
  parameter int IO_DEVICE_COUNT = 16
) (
  input  logic [3:0]                 iIndex,
  input  logic                       iRead,
  input  logic                       iWrite,
  output logic [IO_DEVICE_COUNT-1:0] oIoRead,
  output logic [IO_DEVICE_COUNT-1:0] oIoWrite,
  output logic                       oInRange
);

  logic [IO_DEVICE_COUNT-1:0] sel;

  always_comb begin
    sel = '0;
    for (int i = 0; i < IO_DEVICE_COUNT; i++) begin
      sel[i] = (iIndex == 4'(i));
    end
  end

  // An index past the last device matches no select bit
  assign oInRange = |sel;
  assign oIoRead  = iRead  ? sel : '0;
  assign oIoWrite = iWrite ? sel : '0;

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing
// with ready-handshake stalls, memory-mapped I/O selects and access timeout.
module multi_cycle_controller
  import cpu_defs::*;
#(
  parameter int ADDR_HIGH_WIDTH = 22,
  parameter int IO_DEVICE_COUNT = 16,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int TIMEOUT_WIDTH   = 8
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [5:0]                 iOperationCode,
  input  logic [5:0]                 iFunctionCode,
  input  logic                       iAluZero,
  input  logic [ADDR_HIGH_WIDTH-1:0] iAluResultHigh,
  input  logic [3:0]                 iAluResult7to4,
  input  logic                       iMemReady,
  output logic                       oInstrRead,
  output logic                       oIrWrite,
  output logic                       oPcWrite,
  output logic [1:0]                 oPcSource,
  output logic                       oDoMemoryRead,
  output logic                       oDoMemoryWrite,
  output logic [IO_DEVICE_COUNT-1:0] oIoRead,
  output logic [IO_DEVICE_COUNT-1:0] oIoWrite,
  output logic                       oDoWriteReg,
  output logic                       oIsRdOrRtWritten,
  output logic                       oIsLinkWrite,
  output logic                       oIsRegFromMemOrIo,
  output logic                       oIsAluSource2FromImm,
  output logic                       oIsShift,
  output logic [1:0]                 oAluOp,
  output logic                       oBusError,
  output logic                       oIllegalOp,
  output logic [2:0]                 oState
);

  state_e                   state_q, state_d;
  logic [5:0]               op_q, op_d;
  logic [5:0]               fn_q, fn_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

  logic                       is_lw, is_sw, is_io;
  logic                       io_rd_req, io_wr_req, io_in_range;
  logic                       timeout_hit;
  logic [IO_DEVICE_COUNT-1:0] io_rd, io_wr;

  assign is_lw       = (op_q == OP_LW);
  assign is_sw       = (op_q == OP_SW);
  assign is_io       = (iAluResultHigh == {ADDR_HIGH_WIDTH{IO_ADDR_HIGH_FILL}});
  assign io_rd_req   = (state_q == S_MEM) && is_io && is_lw;
  assign io_wr_req   = (state_q == S_MEM) && is_io && is_sw;
  assign timeout_hit = (cnt_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

  io_device_decoder #(
    .IO_DEVICE_COUNT(IO_DEVICE_COUNT)
  ) u_io_dec (
    .iIndex  (iAluResult7to4),
    .iRead   (io_rd_req),
    .iWrite  (io_wr_req),
    .oIoRead (io_rd),
    .oIoWrite(io_wr),
    .oInRange(io_in_range)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    op_d                 = op_q;
    fn_d                 = fn_q;
    cnt_d                = '0;
    oInstrRead           = 1'b0;
    oIrWrite             = 1'b0;
    oPcWrite             = 1'b0;
    oPcSource            = PC_SRC_PLUS4;
    oDoMemoryRead        = 1'b0;
    oDoMemoryWrite       = 1'b0;
    oIoRead              = '0;
    oIoWrite             = '0;
    oDoWriteReg          = 1'b0;
    oIsRdOrRtWritten     = 1'b0;
    oIsLinkWrite         = 1'b0;
    oIsRegFromMemOrIo    = 1'b0;
    oIsAluSource2FromImm = 1'b0;
    oIsShift             = 1'b0;
    oAluOp               = ALU_OP_MEM;
    oBusError            = 1'b0;
    oIllegalOp           = 1'b0;
    oState               = state_q;

    case (state_q)
      S_FETCH: begin
        oInstrRead = 1'b1;
        if (iMemReady) begin
          oIrWrite  = 1'b1;
          oPcWrite  = 1'b1;
          op_d      = iOperationCode;
          fn_d      = iFunctionCode;
          state_d   = S_DECODE;
        end else if (timeout_hit) begin
          // PC was not advanced, so staying in FETCH retries the same address
          oBusError = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        if (is_known_op(op_q)) begin
          state_d = S_EXECUTE;
        end else begin
          oIllegalOp = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_EXECUTE: begin
        oIsAluSource2FromImm = is_arith_i(op_q) || is_lw || is_sw;
        if (op_q == OP_RTYPE) begin
          oAluOp   = ALU_OP_FUNCT;
          oIsShift = is_shift_funct(fn_q);
          if (fn_q == FN_JR) begin
            oPcWrite  = 1'b1;
            oPcSource = PC_SRC_REG;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (is_arith_i(op_q)) begin
          oAluOp  = ALU_OP_FUNCT;
          state_d = S_WRITEBACK;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if ((op_q == OP_BEQ) || (op_q == OP_BNE)) begin
          oAluOp    = ALU_OP_BRANCH;
          oPcWrite  = (op_q == OP_BEQ) ? iAluZero : !iAluZero;
          oPcSource = PC_SRC_BRANCH;
          state_d   = S_FETCH;
        end else begin
          oPcWrite     = 1'b1;
          oPcSource    = PC_SRC_JUMP;
          oDoWriteReg  = (op_q == OP_JAL);
          oIsLinkWrite = (op_q == OP_JAL);
          state_d      = S_FETCH;
        end
      end

      S_MEM: begin
        oDoMemoryRead  = is_lw && !is_io;
        oDoMemoryWrite = is_sw && !is_io;
        oIoRead        = io_rd;
        oIoWrite       = io_wr;
        // A nonexistent device can never answer, so its ready is not trusted
        if (iMemReady && (!is_io || io_in_range)) begin
          state_d = is_lw ? S_WRITEBACK : S_FETCH;
        end else if (timeout_hit) begin
          oBusError = 1'b1;
          state_d   = S_FETCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WRITEBACK: begin
        oDoWriteReg       = 1'b1;
        oIsRdOrRtWritten  = (op_q == OP_RTYPE);
        oIsRegFromMemOrIo = is_lw;
        state_d           = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    if (iRst) begin
      oInstrRead           = 1'b0;
      oIrWrite             = 1'b0;
      oPcWrite             = 1'b0;
      oPcSource            = PC_SRC_PLUS4;
      oDoMemoryRead        = 1'b0;
      oDoMemoryWrite       = 1'b0;
      oIoRead              = '0;
      oIoWrite             = '0;
      oDoWriteReg          = 1'b0;
      oIsRdOrRtWritten     = 1'b0;
      oIsLinkWrite         = 1'b0;
      oIsRegFromMemOrIo    = 1'b0;
      oIsAluSource2FromImm = 1'b0;
      oIsShift             = 1'b0;
      oAluOp               = ALU_OP_MEM;
      oBusError            = 1'b0;
      oIllegalOp           = 1'b0;
      oState               = 3'd0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: per-instruction transaction model builds the
// expected per-cycle control vector; directed cases plus randomized instruction mix.
module tb_multi_cycle_controller;

  localparam int AW = 22;
  localparam int N  = 12;
  localparam int T  = 4;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [5:0]    op = '0, fn = '0;
  logic          zero = 1'b0;
  logic [AW-1:0] high = '0;
  logic [3:0]    idx = '0;
  logic          ready = 1'b0;

  logic          oInstrRead, oIrWrite, oPcWrite, oDoMemoryRead, oDoMemoryWrite;
  logic [1:0]    oPcSource, oAluOp;
  logic [N-1:0]  oIoRead, oIoWrite;
  logic          oDoWriteReg, oIsRdOrRtWritten, oIsLinkWrite, oIsRegFromMemOrIo;
  logic          oIsAluSource2FromImm, oIsShift, oBusError, oIllegalOp;
  logic [2:0]    oState;

  multi_cycle_controller #(
    .ADDR_HIGH_WIDTH(AW), .IO_DEVICE_COUNT(N), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(TW)
  ) dut (
    .iClk(clk), .iRst(rst), .iOperationCode(op), .iFunctionCode(fn),
    .iAluZero(zero), .iAluResultHigh(high), .iAluResult7to4(idx), .iMemReady(ready),
    .oInstrRead(oInstrRead), .oIrWrite(oIrWrite), .oPcWrite(oPcWrite), .oPcSource(oPcSource),
    .oDoMemoryRead(oDoMemoryRead), .oDoMemoryWrite(oDoMemoryWrite),
    .oIoRead(oIoRead), .oIoWrite(oIoWrite), .oDoWriteReg(oDoWriteReg),
    .oIsRdOrRtWritten(oIsRdOrRtWritten), .oIsLinkWrite(oIsLinkWrite),
    .oIsRegFromMemOrIo(oIsRegFromMemOrIo), .oIsAluSource2FromImm(oIsAluSource2FromImm),
    .oIsShift(oIsShift), .oAluOp(oAluOp), .oBusError(oBusError), .oIllegalOp(oIllegalOp),
    .oState(oState)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]   state;
    logic         instr_read, ir_write, pc_write;
    logic [1:0]   pc_src;
    logic         mrd, mwr;
    logic [N-1:0] io_rd, io_wr;
    logic         wreg, rd, link, from_mem, imm, shift;
    logic [1:0]   alu_op;
    logic         bus_err, illegal;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n_cyc, n_wreg, n_io2, n_berr, n_ill, n_mwr, n_pcw, n_iosel;

  logic [5:0]    cur_op, cur_fn;
  logic          cur_zero;
  logic [AW-1:0] cur_high;
  logic [3:0]    cur_idx;

  function automatic vec_t act_vec();
    vec_t a;
    a.state = oState; a.instr_read = oInstrRead; a.ir_write = oIrWrite;
    a.pc_write = oPcWrite; a.pc_src = oPcSource; a.mrd = oDoMemoryRead;
    a.mwr = oDoMemoryWrite; a.io_rd = oIoRead; a.io_wr = oIoWrite;
    a.wreg = oDoWriteReg; a.rd = oIsRdOrRtWritten; a.link = oIsLinkWrite;
    a.from_mem = oIsRegFromMemOrIo; a.imm = oIsAluSource2FromImm; a.shift = oIsShift;
    a.alu_op = oAluOp; a.bus_err = oBusError; a.illegal = oIllegalOp;
    return a;
  endfunction

  function automatic vec_t base(input int st);
    vec_t e = '0;
    e.state = 3'(st);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic clr();
    n_cyc = 0; n_wreg = 0; n_io2 = 0; n_berr = 0; n_ill = 0; n_mwr = 0; n_pcw = 0; n_iosel = 0;
  endtask

  // One clock cycle: drive at posedge+1, compare the settled outputs at negedge
  task automatic do_cycle(input logic rdy, input logic instr_valid, input vec_t e);
    vec_t a;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = rdy;
    if (instr_valid) begin
      op = cur_op; fn = cur_fn;
    end else begin
      op = 6'($urandom); fn = 6'($urandom);
    end
    zero = cur_zero; high = cur_high; idx = cur_idx;
    @(negedge clk);
    a = act_vec();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle state=%0d: got %h expected %h", e.state, a, e);
    end
    n_cyc++;
    if (a.wreg) n_wreg++;
    if (a.io_rd == 12'h002) n_io2++;
    if (a.bus_err) n_berr++;
    if (a.illegal) n_ill++;
    if (a.mwr) n_mwr++;
    if (a.pc_write) n_pcw++;
    if ((|a.io_rd) || (|a.io_wr)) n_iosel++;
  endtask

  task automatic fetch_phase(input int waits);
    vec_t e;
    int w = waits;
    while (w > T) begin
      e = base(0); e.instr_read = 1'b1;
      for (int i = 0; i < T; i++) do_cycle(1'b0, 1'b1, e);
      e.bus_err = 1'b1;
      do_cycle(1'b0, 1'b1, e);
      w = int'($urandom_range(0, T));
    end
    e = base(0); e.instr_read = 1'b1;
    for (int i = 0; i < w; i++) do_cycle(1'b0, 1'b1, e);
    e.ir_write = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd0;
    do_cycle(1'b1, 1'b1, e);
  endtask

  // Expected behaviour of one whole instruction, from fetch to return to FETCH
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                           input logic z, input logic [AW-1:0] h, input logic [3:0] ix,
                           input int mw, input int abort_mem);
    vec_t e, m;
    logic is_r, is_ai, is_lw, is_sw, legal, to_wb, to_mem, io, sel_ok;
    int   w;
    cur_op = o; cur_fn = f; cur_zero = z; cur_high = h; cur_idx = ix;
    is_r  = (o == 6'b000000);
    is_ai = (o[5:3] == 3'b001);
    is_lw = (o == 6'b100011);
    is_sw = (o == 6'b101011);
    legal = is_r || is_ai || is_lw || is_sw || (o == 6'b000100) || (o == 6'b000101) ||
            (o == 6'b000010) || (o == 6'b000011);
    fetch_phase(fw);

    e = base(1);
    if (!legal) begin
      e.illegal = 1'b1;
      do_cycle(1'($urandom), 1'b0, e);
      return;
    end
    do_cycle(1'($urandom), 1'b0, e);

    e = base(2); to_wb = 1'b0; to_mem = 1'b0;
    e.imm = is_ai || is_lw || is_sw;
    if (is_r) begin
      e.alu_op = 2'b10;
      e.shift  = f inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
      if (f == 6'b001000) begin e.pc_write = 1'b1; e.pc_src = 2'd3; end
      else to_wb = 1'b1;
    end else if (is_ai) begin
      e.alu_op = 2'b10; to_wb = 1'b1;
    end else if (is_lw || is_sw) begin
      to_mem = 1'b1;
    end else if (o == 6'b000100 || o == 6'b000101) begin
      e.alu_op = 2'b01; e.pc_src = 2'd1;
      e.pc_write = (o == 6'b000100) ? z : !z;
    end else begin
      e.pc_write = 1'b1; e.pc_src = 2'd2;
      if (o == 6'b000011) begin e.wreg = 1'b1; e.link = 1'b1; end
    end
    do_cycle(1'($urandom), 1'b0, e);

    if (to_mem) begin
      io     = (h == '1);
      sel_ok = !io || (int'(ix) < N);
      m = base(3);
      if (io && sel_ok) begin
        if (is_lw) m.io_rd[ix] = 1'b1; else m.io_wr[ix] = 1'b1;
      end else if (!io) begin
        m.mrd = is_lw; m.mwr = is_sw;
      end
      if (abort_mem >= 0) begin
        for (int i = 0; i < abort_mem; i++) do_cycle(1'b0, 1'b0, m);
        return;
      end
      w = sel_ok ? mw : T + 1;
      if (w <= T) begin
        for (int i = 0; i < w; i++) do_cycle(1'b0, 1'b0, m);
        do_cycle(1'b1, 1'b0, m);
        to_wb = is_lw;
      end else begin
        // no device answers an out-of-range index, so ready is irrelevant there
        for (int i = 0; i < T; i++) do_cycle(sel_ok ? 1'b0 : 1'($urandom), 1'b0, m);
        m.bus_err = 1'b1;
        do_cycle(sel_ok ? 1'b0 : 1'($urandom), 1'b0, m);
      end
    end

    if (to_wb) begin
      e = base(4); e.wreg = 1'b1; e.rd = is_r; e.from_mem = is_lw;
      do_cycle(1'($urandom), 1'b0, e);
    end
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;

  initial begin
    logic [5:0] ops [0:11];
    logic [5:0] fns [0:7];
    logic [5:0] o, f;
    ops = '{6'b000000, 6'b000000, 6'b001000, 6'b001101, LW, SW, BEQ, 6'b000101,
            6'b000010, 6'b000011, 6'b111111, 6'b010001};
    fns = '{6'b100000, 6'b100010, 6'b000000, 6'b000011, 6'b000110, 6'b001000,
            6'b000111, 6'b101010};
    clr();

    ready = 1'b1;
    #2;
    chk("reset_outputs_zero", int'(act_vec() != '0), 0);

    clr(); run_instr(6'b000000, 6'b100000, 0, 1'b0, '0, 4'd0, 0, -1);
    chk("add_cycles", n_cyc, 4);
    chk("add_writereg_cycles", n_wreg, 1);

    clr(); run_instr(LW, 6'd0, 0, 1'b0, '1, 4'd1, 2, -1);
    chk("lw_io1_select_cycles", n_io2, 3);
    chk("lw_io1_writereg", n_wreg, 1);

    clr(); run_instr(SW, 6'd0, 0, 1'b0, '0, 4'd0, 0, -1);
    chk("sw_mem_write_cycles", n_mwr, 1);
    chk("sw_no_writereg", n_wreg, 0);
    chk("sw_no_io_select", n_iosel, 0);

    clr(); run_instr(BEQ, 6'd0, 0, 1'b1, '0, 4'd0, 0, -1);
    chk("beq_taken_pcwrites", n_pcw, 2);
    clr(); run_instr(BEQ, 6'd0, 0, 1'b0, '0, 4'd0, 0, -1);
    chk("beq_not_taken_pcwrites", n_pcw, 1);

    clr(); run_instr(LW, 6'd0, 0, 1'b0, '1, 4'd5, T + 1, -1);
    chk("lw_timeout_buserr", n_berr, 1);
    chk("lw_timeout_no_writereg", n_wreg, 0);
    chk("lw_timeout_cycles", n_cyc, 8);

    clr(); run_instr(LW, 6'd0, 0, 1'b0, '0, 4'd0, T, -1);
    chk("ready_at_limit_no_error", n_berr, 0);
    chk("ready_at_limit_writereg", n_wreg, 1);

    clr(); run_instr(LW, 6'd0, 0, 1'b0, '1, 4'd13, 0, -1);
    chk("io_out_of_range_buserr", n_berr, 1);
    chk("io_out_of_range_no_select", n_iosel, 0);

    clr(); run_instr(6'b000000, 6'b100000, T + 1, 1'b0, '0, 4'd0, 0, -1);
    chk("fetch_timeout_buserr", n_berr, 1);

    clr(); run_instr(6'b111111, 6'd0, 0, 1'b0, '0, 4'd0, 0, -1);
    chk("illegal_pulses", n_ill, 1);
    chk("illegal_cycles", n_cyc, 2);

    run_instr(SW, 6'd0, 0, 1'b0, '0, 4'd0, 0, 2);
    #1;
    rst = 1'b1; ready = 1'b1;
    #1;
    chk("reset_mid_mem_outputs_zero", int'(act_vec() != '0), 0);
    @(posedge clk);
    #2;
    chk("reset_held_outputs_zero", int'(act_vec() != '0), 0);
    run_instr(6'b000000, 6'b100000, 0, 1'b0, '0, 4'd0, 0, -1);

    for (int n = 0; n < 150; n++) begin
      o = ops[$urandom_range(0, 11)];
      f = fns[$urandom_range(0, 7)];
      if (o == 6'b001000) o = {3'b001, 3'($urandom)};
      run_instr(o, f, int'($urandom_range(0, 5)), 1'($urandom),
                ($urandom_range(0, 1) == 1) ? '1 : AW'($urandom), 4'($urandom),
                int'($urandom_range(0, 5)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
